// File: rtl/pulseack_event_issuer_pkg.sv
// Shared types and constants for the pulse-acknowledge event issuer.
package pulseack_issuer_pkg;

   // Issuer FSM: wait for work, drive the event pulse, then wait for the ack.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   // Width of the WAIT_ACK cycle counter used by the optional timeout.
   localparam int TMO_CNT_W = 16;

   // Legal range for the pending counter width.
   localparam int CNT_WIDTH_MIN = 1;
   localparam int CNT_WIDTH_MAX = 8;

endpackage

// File: rtl/pulseack_event_issuer_if.sv
// Source-side handshake toward the pulse-acknowledge synchronizer.
// master: the issuer (drives event_s); slave: the synchronizer.
interface pulseack_sync_if;
   logic event_s;
   logic busy_s;
   logic ack_s;

   modport master (output event_s, input busy_s, input ack_s);
   modport slave  (input event_s, output busy_s, output ack_s);
endinterface

// File: rtl/pulseack_event_issuer_pending_cnt.sv
// Saturating up/down counter of queued requests with a sticky overflow flag.
// An increment at full scale is dropped (and flagged) unless a decrement
// frees a slot in the same cycle.
module pulseack_pending_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             dec_ok;

   // Next count: clear wins, then inc/dec with saturation at full scale.
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      dec_ok = dec && (cnt_q != '0);
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         case ({inc, dec_ok})
            2'b10: begin
               if (cnt_q == CNT_MAX) ovf_d = 1'b1;
               else                  cnt_d = cnt_q + WIDTH'(1);
            end
            2'b01:   cnt_d = cnt_q - WIDTH'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Count and sticky overflow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign count    = cnt_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/pulseack_event_issuer.sv
// Source-domain initiator for a pulse-acknowledge synchronizer: queues local
// requests and issues them one at a time as event_s pulses, waiting for
// ack_s between issues.
// Optional feature: define PULSEACK_ISSUER_TIMEOUT_EN to abandon an event
// that is not acknowledged within timeout_cycles WAIT_ACK cycles and raise
// the sticky timeout_err output.
module pulseack_event_issuer
   import pulseack_issuer_pkg::*;
#(
   parameter int cnt_width      = 4,
   parameter int timeout_cycles = 255
) (
   input  logic                 clk_s,
   input  logic                 rst_s,
   input  logic                 init_s_n,
   input  logic                 req_s,
   pulseack_sync_if.master      sync,
   output logic                 done_s,
   output logic [cnt_width-1:0] pending,
   output logic                 outstanding,
   output logic                 overflow
`ifdef PULSEACK_ISSUER_TIMEOUT_EN
   ,
   output logic                 timeout_err
`endif
);

   state_e state_q, state_d;
   logic   event_q, event_d;
   logic   done_q,  done_d;
   logic   outst_q, outst_d;
   logic   deq;

`ifdef PULSEACK_ISSUER_TIMEOUT_EN
   // Last WAIT_ACK cycle index before the event is abandoned.
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(timeout_cycles - 1);

   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 tmo_err_q, tmo_err_d;
`endif

   // Queue of requests not yet issued; the IDLE->ISSUE step is the dequeue.
   pulseack_pending_cnt #(
      .WIDTH (cnt_width)
   ) u_pending_cnt (
      .clk      (clk_s),
      .rst      (rst_s),
      .clr      (~init_s_n),
      .inc      (req_s),
      .dec      (deq),
      .count    (pending),
      .overflow (overflow)
   );

   // Next state and registered pulse outputs; sync clear forces everything idle.
   always_comb begin
      state_d = state_q;
      event_d = 1'b0;
      done_d  = 1'b0;
      outst_d = outst_q;
      deq     = 1'b0;
`ifdef PULSEACK_ISSUER_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      case (state_q)
         IDLE: begin
            // busy_s only matters here; while it is high requests keep piling up.
            if ((pending != '0) && !sync.busy_s) begin
               deq     = 1'b1;
               state_d = ISSUE;
               event_d = 1'b1;
               outst_d = 1'b1;
            end
         end
         ISSUE: begin
            state_d = WAIT_ACK;
`ifdef PULSEACK_ISSUER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         WAIT_ACK: begin
            // An ack on the limit cycle still counts as a normal completion.
            if (sync.ack_s) begin
               state_d = IDLE;
               done_d  = 1'b1;
               outst_d = 1'b0;
            end
`ifdef PULSEACK_ISSUER_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = IDLE;
               outst_d   = 1'b0;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (!init_s_n) begin
         state_d = IDLE;
         event_d = 1'b0;
         done_d  = 1'b0;
         outst_d = 1'b0;
`ifdef PULSEACK_ISSUER_TIMEOUT_EN
         tmo_cnt_d = '0;
         tmo_err_d = 1'b0;
`endif
      end
   end

   // State and output registers, cleared asynchronously by rst_s.
   always_ff @(posedge clk_s or posedge rst_s) begin
      if (rst_s) begin
         state_q <= IDLE;
         event_q <= 1'b0;
         done_q  <= 1'b0;
         outst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         event_q <= event_d;
         done_q  <= done_d;
         outst_q <= outst_d;
      end
   end

`ifdef PULSEACK_ISSUER_TIMEOUT_EN
   // WAIT_ACK cycle counter and sticky timeout flag.
   always_ff @(posedge clk_s or posedge rst_s) begin
      if (rst_s) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign timeout_err = tmo_err_q;
`endif

   assign sync.event_s = event_q;
   assign done_s       = done_q;
   assign outstanding  = outst_q;

endmodule
